// File: rtl/adc_conv_sequencer_if.sv
// rtl/adc_conv_sequencer_if.sv - request, status and edge-detector signals of the conversion sequencer
interface adc_conv_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             conv_req;
    logic             conv_ready;
    logic             continuous;
    logic             free_run;
    logic             sar_done_async;
    logic             start_conv;
    logic             ena_in;
    logic             busy;
    logic             conv_done;
    logic             conv_timeout;
    logic [CNT_W-1:0] conv_count;
    logic [7:0]       timeout_count;

    modport master (
        output conv_req, continuous, free_run, sar_done_async,
        input  conv_ready, start_conv, ena_in, busy, conv_done, conv_timeout,
               conv_count, timeout_count
    );

    modport slave (
        input  conv_req, continuous, free_run, sar_done_async,
        output conv_ready, start_conv, ena_in, busy, conv_done, conv_timeout,
               conv_count, timeout_count
    );
endinterface

// File: rtl/adc_conv_sequencer.sv
// rtl/adc_conv_sequencer.sv - start_conv generator with min high/low times, done/timeout tracking
module adc_conv_sequencer #(
    parameter int HOLD_CYCLES    = 50,
    parameter int LOW_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_conv_sequencer_if.slave  bus
);

    localparam int CMAX0 = (HOLD_CYCLES > LOW_CYCLES) ? HOLD_CYCLES : LOW_CYCLES;
    localparam int CMAX  = (CMAX0 > TIMEOUT_CYCLES) ? CMAX0 : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic             ena_q;
    logic [2:0]       sync_q;
    logic             rise;

    // sync_q[0..2] are s1..s3; only a fresh low-to-high edge of the SAR flag counts
    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        start_d = start_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        count_d = count_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.conv_req || bus.continuous) begin
                    state_d = ST_ARM;
                    start_d = 1'b1;
                end
            end
            ST_ARM: begin
                // a rise seen here belongs to the previous conversion and is dropped
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (rise) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                    start_d = 1'b0;
                    done_d  = 1'b1;
                    count_d = count_q + CNT_W'(1);
                end else if (cnt_q == TMO_LAST) begin
                    state_d = ST_RECOVER;
                    cnt_d   = '0;
                    start_d = 1'b0;
                    tmo_d   = 1'b1;
                    tcnt_d  = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                end
            end
            default: begin
                start_d = 1'b0;
                if (cnt_q == LOW_LAST) begin
                    state_d = bus.continuous ? ST_ARM : ST_IDLE;
                    cnt_d   = '0;
                    start_d = bus.continuous;
                end
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RECOVER;
            cnt_q   <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            count_q <= '0;
            tcnt_q  <= '0;
            ena_q   <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
            tcnt_q  <= tcnt_d;
            ena_q   <= bus.free_run;
            sync_q  <= {sync_q[1:0], bus.sar_done_async};
        end
    end

    assign bus.conv_ready    = ready_q;
    assign bus.start_conv    = start_q;
    assign bus.ena_in        = ena_q;
    assign bus.busy          = busy_q;
    assign bus.conv_done     = done_q;
    assign bus.conv_timeout  = tmo_q;
    assign bus.conv_count    = count_q;
    assign bus.timeout_count = tcnt_q;

endmodule
